// File: rtl/lp_filter_ctrl.sv
// lp_filter_ctrl: sequencer in front of the laser low_pass filter (clear, warm-up discard, run).
// Optional raw warm-up bypass to the downstream port: define LP_WARMUP_BYPASS_EN.
module lp_filter_ctrl #(
    parameter  int LP_DEPTH   = 8,
    parameter  int DATA_WIDTH = 16,
    parameter  int FLUSH_CYC  = 4,
    localparam int DW         = $clog2(LP_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_wr_i,
    input  logic [DW-1:0]         cfg_depth_i,
    input  logic                  laser_vld_i,
    input  logic [DATA_WIDTH-1:0] laser_data_i,
    output logic                  lp_clr_o,
    output logic [DW-1:0]         lp_depth_o,
    output logic                  lp_vld_o,
    output logic [DATA_WIDTH-1:0] lp_data_o,
    input  logic                  lp_vld_i,
    input  logic [DATA_WIDTH-1:0] lp_data_i,
    output logic                  out_vld_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            state_o,
    output logic [15:0]           drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_e;

    localparam int FW = $clog2(FLUSH_CYC + 1);

    state_e          state, state_nxt;
    logic [FW-1:0]   flush_cnt;
    logic [DW-1:0]   prime_cnt;
    logic [DW-1:0]   depth_r;
    logic [DW-1:0]   depth_clamped;
    logic            warmup, fwd_en, run_take;

    assign depth_clamped = (cfg_depth_i == '0 || cfg_depth_i > DW'(LP_DEPTH))
                         ? DW'(LP_DEPTH) : cfg_depth_i;
    assign warmup   = (state == IDLE) || (state == FLUSH);
    assign fwd_en   = (state == PRIME) || (state == RUN);
    assign run_take = (state == RUN) && (state_nxt == RUN) && lp_vld_i;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FW'(FLUSH_CYC - 1)) state_nxt = PRIME;
            PRIME:   if (lp_vld_i && (prime_cnt + DW'(1) == depth_r)) state_nxt = RUN;
            default: state_nxt = state;
        endcase
        // Reconfiguration restarts the warm-up; disabling overrides everything.
        if (cfg_wr_i && state != IDLE) state_nxt = FLUSH;
        if (!cfg_en_i)                 state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            depth_r    <= DW'(LP_DEPTH);
            flush_cnt  <= '0;
            prime_cnt  <= '0;
            lp_clr_o   <= 1'b1;
            lp_vld_o   <= 1'b0;
            lp_data_o  <= '0;
            out_vld_o  <= 1'b0;
            out_data_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_wr_i) depth_r <= depth_clamped;

            flush_cnt <= (state == FLUSH && state_nxt == FLUSH && !cfg_wr_i)
                       ? flush_cnt + FW'(1) : '0;
            prime_cnt <= (state == PRIME && state_nxt == PRIME)
                       ? prime_cnt + DW'(lp_vld_i) : '0;

            // Clear tracks the registered state so it is high exactly in IDLE and FLUSH.
            lp_clr_o <= (state_nxt == IDLE) || (state_nxt == FLUSH);

            if (fwd_en) begin
                lp_vld_o  <= laser_vld_i;
                lp_data_o <= laser_data_i;
            end else begin
                lp_vld_o  <= 1'b0;
            end

`ifdef LP_WARMUP_BYPASS_EN
            if (state != RUN) begin
                out_vld_o <= laser_vld_i;
                if (laser_vld_i) out_data_o <= laser_data_i;
            end else begin
                out_vld_o <= run_take;
                if (run_take) out_data_o <= lp_data_i;
            end
            drop_cnt_o <= '0;
`else
            out_vld_o <= run_take;
            if (run_take) out_data_o <= lp_data_i;
            if (warmup && laser_vld_i && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
`endif
        end
    end

    assign lp_depth_o = depth_r;
    assign state_o    = state;

endmodule

// File: tb/tb_lp_filter_ctrl.sv
// Self-checking bench for lp_filter_ctrl: directed sequences, a depth-clamp table and
// randomized traffic compared every cycle against a countdown-based reference model.
module tb_lp_filter_ctrl;

    localparam int LP_DEPTH   = 8;
    localparam int DATA_WIDTH = 16;
    localparam int FLUSH_CYC  = 4;
    localparam int DW         = $clog2(LP_DEPTH) + 1;
`ifdef LP_WARMUP_BYPASS_EN
    localparam int SAT_LIMIT  = 200;
`else
    localparam int SAT_LIMIT  = 70000;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  cfg_en_i = 1'b0, cfg_wr_i = 1'b0;
    logic [DW-1:0]         cfg_depth_i = '0;
    logic                  laser_vld_i = 1'b0, lp_vld_i = 1'b0;
    logic [DATA_WIDTH-1:0] laser_data_i = '0, lp_data_i = '0;
    logic                  lp_clr_o, lp_vld_o, out_vld_o;
    logic [DW-1:0]         lp_depth_o;
    logic [DATA_WIDTH-1:0] lp_data_o, out_data_o;
    logic [1:0]            state_o;
    logic [15:0]           drop_cnt_o;

    lp_filter_ctrl #(.LP_DEPTH(LP_DEPTH), .DATA_WIDTH(DATA_WIDTH), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_wr_i(cfg_wr_i),
        .cfg_depth_i(cfg_depth_i), .laser_vld_i(laser_vld_i), .laser_data_i(laser_data_i),
        .lp_clr_o(lp_clr_o), .lp_depth_o(lp_depth_o), .lp_vld_o(lp_vld_o), .lp_data_o(lp_data_o),
        .lp_vld_i(lp_vld_i), .lp_data_i(lp_data_i), .out_vld_o(out_vld_o),
        .out_data_o(out_data_o), .state_o(state_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0..3, warm-up expressed as remaining flush cycles / discards.
    int                    m_state, m_flush_left, m_disc_left, m_depth, m_drop;
    logic                  e_clr, e_vld, e_ovld;
    logic [DATA_WIDTH-1:0] e_data, e_odata;

    task automatic model_reset();
        m_state = 0; m_flush_left = 0; m_disc_left = 0; m_depth = LP_DEPTH; m_drop = 0;
        e_clr = 1'b1; e_vld = 1'b0; e_data = '0; e_ovld = 1'b0; e_odata = '0;
    endtask

    task automatic model_step();
        int  ns;
        bit  take;
        ns = m_state;
        if (!cfg_en_i) ns = 0;
        else if (cfg_wr_i && m_state != 0) begin ns = 1; m_flush_left = FLUSH_CYC; end
        else begin
            case (m_state)
                0: begin ns = 1; m_flush_left = FLUSH_CYC; end
                1: begin
                    m_flush_left--;
                    if (m_flush_left == 0) begin ns = 2; m_disc_left = m_depth; end
                end
                2: if (lp_vld_i) begin
                    m_disc_left--;
                    if (m_disc_left == 0) ns = 3;
                end
                default: ;
            endcase
        end
        if (m_state >= 2) begin e_vld = laser_vld_i; e_data = laser_data_i; end
        else e_vld = 1'b0;
        take = (m_state == 3) && (ns == 3) && lp_vld_i;
`ifdef LP_WARMUP_BYPASS_EN
        if (m_state != 3) begin
            e_ovld = laser_vld_i;
            if (laser_vld_i) e_odata = laser_data_i;
        end else begin
            e_ovld = take;
            if (take) e_odata = lp_data_i;
        end
`else
        e_ovld = take;
        if (take) e_odata = lp_data_i;
        if (m_state <= 1 && laser_vld_i && m_drop < 65535) m_drop++;
`endif
        e_clr = (ns <= 1);
        if (cfg_wr_i)
            m_depth = (cfg_depth_i == 0 || int'(cfg_depth_i) > LP_DEPTH) ? LP_DEPTH : int'(cfg_depth_i);
        m_state = ns;
    endtask

    task automatic compare_all();
        check("state", state_o, m_state);
        check("lp_clr", lp_clr_o, e_clr);
        check("lp_depth", lp_depth_o, m_depth);
        check("lp_vld", lp_vld_o, e_vld);
        check("lp_data", lp_data_o, e_data);
        check("out_vld", out_vld_o, e_ovld);
        check("out_data", out_data_o, e_odata);
        check("drop_cnt", drop_cnt_o, m_drop);
    endtask

    // Inputs change only at posedge+1, so the model and DUT see identical values at the edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_clr"}, lp_clr_o, 1);
        check({tag, "_depth"}, lp_depth_o, LP_DEPTH);
        check({tag, "_lp_vld"}, lp_vld_o, 0);
        check({tag, "_lp_data"}, lp_data_o, 0);
        check({tag, "_out_vld"}, out_vld_o, 0);
        check({tag, "_out_data"}, out_data_o, 0);
        check({tag, "_drop"}, drop_cnt_o, 0);
    endtask

    typedef struct {
        logic [DW-1:0] depth_in;
        logic [DW-1:0] depth_exp;
    } depth_vec_t;

    initial begin
        depth_vec_t dv[8];
        int         pulses, disc, pre, sat_extra;
        logic [DATA_WIDTH-1:0] first_data;

        dv[0] = '{4'd0, 4'd8};  dv[1] = '{4'd1, 4'd1};  dv[2] = '{4'd4, 4'd4};
        dv[3] = '{4'd8, 4'd8};  dv[4] = '{4'd9, 4'd8};  dv[5] = '{4'd12, 4'd8};
        dv[6] = '{4'd15, 4'd8}; dv[7] = '{4'd3, 4'd3};

        // Reset values, then IDLE -> FLUSH x FLUSH_CYC -> PRIME.
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_i = 1'b0;
        cfg_en_i = 1'b1;
        for (int i = 0; i < FLUSH_CYC; i++) begin
            tick();
            check("flush_state", state_o, 1);
            check("flush_clr", lp_clr_o, 1);
        end
        tick();
        check("prime_entry", state_o, 2);
        check("prime_clr", lp_clr_o, 0);

        // Stream 20 samples at depth 8: 8 discarded, the 9th emerges one cycle later.
        pulses = 0; first_data = '0;
        for (int i = 0; i < 20; i++) begin
            laser_vld_i = 1'b1; laser_data_i = 16'h0100;
            lp_vld_i = 1'b1; lp_data_i = 16'h0100 + 16'(i);
            pre = state_o;
            tick();
            if (pre == 3 && out_vld_o) begin
                if (pulses == 0) first_data = out_data_o;
                pulses++;
            end
        end
        check("run_state", state_o, 3);
        check("run_pulses", pulses, 12);
        check("run_first_data", first_data, 16'h0108);

        // Depth 4 written in RUN: restart, 4 discards before RUN.
        lp_vld_i = 1'b0; cfg_wr_i = 1'b1; cfg_depth_i = 4'd4;
        tick();
        cfg_wr_i = 1'b0;
        check("rewr_state", state_o, 1);
        check("rewr_depth", lp_depth_o, 4);
        lp_vld_i = 1'b1; disc = 0;
        for (int i = 0; i < 40 && state_o != 3; i++) begin
            pre = state_o;
            lp_data_i = 16'h0200 + 16'(i);
            tick();
            if (pre == 2) disc++;
        end
        check("rewr_reach_run", state_o, 3);
        check("rewr_discards", disc, 4);
        cfg_wr_i = 1'b1; cfg_depth_i = 4'd12;
        tick();
        cfg_wr_i = 1'b0;
        check("clamp12_depth", lp_depth_o, 8);

        // Disable and reconfigure in the same PRIME cycle.
        for (int i = 0; i < 20 && state_o != 2; i++) tick();
        check("reach_prime", state_o, 2);
        tick(); tick();
        cfg_en_i = 1'b0; cfg_wr_i = 1'b1; cfg_depth_i = 4'd5;
        tick();
        cfg_wr_i = 1'b0;
        check("dis_state", state_o, 0);
        check("dis_clr", lp_clr_o, 1);
        check("dis_depth", lp_depth_o, 5);

        // Asynchronous reset mid-RUN.
        cfg_en_i = 1'b1;
        for (int i = 0; i < 40 && state_o != 3; i++) tick();
        check("reach_run2", state_o, 3);
        tick();
        rst_i = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        tick();
        rst_i = 1'b0;

        // Depth clamp table, applied while disabled.
        cfg_en_i = 1'b0; laser_vld_i = 1'b0; lp_vld_i = 1'b0;
        foreach (dv[i]) begin
            cfg_wr_i = 1'b1; cfg_depth_i = dv[i].depth_in;
            tick();
            check("depth_tbl", lp_depth_o, dv[i].depth_exp);
        end
        cfg_wr_i = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cfg_en_i     = ($urandom_range(0, 99) != 0);
            cfg_wr_i     = ($urandom_range(0, 59) == 0);
            cfg_depth_i  = DW'($urandom_range(0, 15));
            laser_vld_i  = $urandom_range(0, 1) != 0;
            laser_data_i = DATA_WIDTH'($urandom);
            lp_vld_i     = $urandom_range(0, 2) != 0;
            lp_data_i    = DATA_WIDTH'($urandom);
            tick();
        end
        cfg_wr_i = 1'b0; lp_vld_i = 1'b0; laser_vld_i = 1'b0;

`ifdef LP_WARMUP_BYPASS_EN
        // Raw bypass during FLUSH.
        cfg_en_i = 1'b0;
        tick();
        cfg_en_i = 1'b1;
        tick();
        laser_vld_i = 1'b1; laser_data_i = 16'h1234;
        tick();
        laser_vld_i = 1'b0;
        check("bypass_vld", out_vld_o, 1);
        check("bypass_data", out_data_o, 16'h1234);
        check("bypass_drop", drop_cnt_o, 0);
`endif

        // Drop counter saturation while disabled.
        cfg_en_i = 1'b0; laser_vld_i = 1'b1; sat_extra = 0;
        for (int n = 0; n < SAT_LIMIT && sat_extra < 8; n++) begin
            laser_data_i = DATA_WIDTH'(n);
            tick();
            if (m_drop == 65535) sat_extra++;
        end
`ifndef LP_WARMUP_BYPASS_EN
        check("sat_drop", drop_cnt_o, 16'hFFFF);
        check("sat_out_vld", out_vld_o, 0);
`endif
        laser_vld_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
